// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the fetch PC and drives the instruction-memory req/gnt/rvalid port with
// at most one request outstanding. A single-entry buffer holds each fetched word
// for the decoder (valid/ready handshake). Execute can redirect fetch at any
// time. A fetch that was already granted when the redirect arrived is marked
// stale and its response is discarded.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   fetch_en_i          1 = keep issuing fetches; 0 = finish in-flight, then idle
//   redirect_i          one-cycle control-transfer pulse
//   redirect_addr_i     new fetch PC (bits [1:0] ignored)
//   imem_req_o          fetch request (held until granted)
//   imem_addr_o         fetch address, meaningful while imem_req_o=1
//   imem_gnt_i          request accepted
//   imem_rvalid_i       read data valid (at least one cycle after grant)
//   imem_rdata_i        read data
//   instr_valid_o       instruction buffer full
//   instr_o             buffered instruction
//   instr_pc_o          address of instr_o
//   instr_pc_plus4_o    instr_pc_o + 4 (link address)
//   instr_ready_i       decoder consumes the buffer when valid && ready
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = 'h10074
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_plus4_o,
  input  logic                   instr_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_t                 state_reg,       state_next;
  logic [ADDR_WIDTH-1:0]  fetch_pc_reg,    fetch_pc_next;
  logic [ADDR_WIDTH-1:0]  req_pc_reg,      req_pc_next;
  logic                   kill_reg,        kill_next;
  logic                   instr_valid_reg, instr_valid_next;
  logic [INSTR_WIDTH-1:0] instr_reg,       instr_next;
  logic [ADDR_WIDTH-1:0]  instr_pc_reg,    instr_pc_next;

  logic [ADDR_WIDTH-1:0]  redirect_pc;
  state_t                 resume_state;

  // Fetch addresses are word aligned; the low two bits of the target are dropped.
  assign redirect_pc = {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00};

  // Low address bits are intentionally unused.
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_addr_i[1:0];

  // Where to go once the current fetch has been retired or dropped.
  assign resume_state = fetch_en_i ? ST_REQ : ST_IDLE;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      fetch_pc_reg    <= BOOT_ADDR;
      req_pc_reg      <= BOOT_ADDR;
      kill_reg        <= 1'b0;
      instr_valid_reg <= 1'b0;
      instr_reg       <= '0;
      instr_pc_reg    <= BOOT_ADDR;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      req_pc_reg      <= req_pc_next;
      kill_reg        <= kill_next;
      instr_valid_reg <= instr_valid_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    req_pc_next      = req_pc_reg;
    kill_next        = kill_reg;
    instr_valid_next = instr_valid_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;

    // A redirect always wins: the PC jumps to the target and any buffered
    // instruction belongs to the wrong path.
    if (redirect_i) begin
      fetch_pc_next    = redirect_pc;
      instr_valid_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        // A redirect in IDLE only retargets the PC; fetching resumes next cycle.
        if (!redirect_i && fetch_en_i) begin
          state_next = ST_REQ;
        end
      end

      ST_REQ: begin
        // The request is never withdrawn, even if fetch_en_i drops. Without a
        // grant a redirect just changes the address still being presented.
        if (imem_gnt_i) begin
          state_next  = ST_WAIT;
          req_pc_next = fetch_pc_reg;
          if (redirect_i) begin
            // Memory already accepted the old address, so its data is stale.
            // The PC goes to the target itself, not target + 4.
            kill_next = 1'b1;
          end else begin
            fetch_pc_next = fetch_pc_reg + PC_STEP;
          end
        end
      end

      ST_WAIT: begin
        if (imem_rvalid_i) begin
          if (redirect_i || kill_reg) begin
            // Stale response: drop it. Kill never needs to outlive this beat.
            kill_next  = 1'b0;
            state_next = resume_state;
          end else begin
            instr_next       = imem_rdata_i;
            instr_pc_next    = req_pc_reg;
            instr_valid_next = 1'b1;
            state_next       = ST_HOLD;
          end
        end else if (redirect_i) begin
          kill_next = 1'b1;
        end
      end

      ST_HOLD: begin
        // The buffer is always full in HOLD. A redirect empties it exactly as a
        // consume would, so a simultaneous ready needs no special treatment.
        if (redirect_i || instr_ready_i) begin
          instr_valid_next = 1'b0;
          state_next       = resume_state;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_req_o       = (state_reg == ST_REQ);
  assign imem_addr_o      = fetch_pc_reg;
  assign instr_valid_o    = instr_valid_reg;
  assign instr_o          = instr_reg;
  assign instr_pc_o       = instr_pc_reg;
  assign instr_pc_plus4_o = instr_pc_reg + PC_STEP;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed vector table for the fetch sequencing corner cases, followed by a
// randomized run against a transaction-level memory and fetch-stream model.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        instr_ready;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_WIDTH (32),
    .INSTR_WIDTH(32),
    .BOOT_ADDR  (32'h10074)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en_i      (fetch_en),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_gnt_i      (imem_gnt),
    .imem_rvalid_i   (imem_rvalid),
    .imem_rdata_i    (imem_rdata),
    .instr_valid_o   (instr_valid),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .instr_pc_plus4_o(instr_pc_plus4),
    .instr_ready_i   (instr_ready)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  // Memory contents as seen by the bench: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vectors. Each row: expected outputs observed at the falling edge,
  // then the inputs applied for the following rising edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst_n, en, redir;
    logic [31:0] raddr;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] einstr, eipc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, e, d, input logic [31:0] da, input logic g, v,
                     input logic [31:0] rd, input logic y, input logic er,
                     input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                     input logic [31:0] ep);
    vec_t t;
    t.rst_n = r; t.en = e; t.redir = d; t.raddr = da; t.gnt = g; t.rv = v;
    t.rdata = rd; t.rdy = y; t.ereq = er; t.eaddr = ea; t.ev = ev;
    t.einstr = ei; t.eipc = ep;
    vecs.push_back(t);
  endtask

  task automatic build_vectors();
    //   rst en rd raddr         g  rv rdata        rdy | req addr         v  instr        ipc
    // basic fetch: gnt with req, rvalid next cycle
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h10074,    0, 32'h0,        32'h10074); // 0
    add(1, 1, 0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h10074,    0, 32'h0,        32'h10074); // 1
    add(1, 1, 0, 32'h0,        0, 1, 32'h11111111, 1,   0, 32'h10078,    0, 32'h0,        32'h10074); // 2
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h10078,    1, 32'h11111111, 32'h10074); // 3
    // grant held off three cycles
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h10078,    0, 32'h11111111, 32'h10074); // 4
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h10078,    0, 32'h11111111, 32'h10074); // 5
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h10078,    0, 32'h11111111, 32'h10074); // 6
    add(1, 1, 0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h10078,    0, 32'h11111111, 32'h10074); // 7
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h1007C,    0, 32'h11111111, 32'h10074); // 8
    // decoder stalls in HOLD
    add(1, 1, 0, 32'h0,        0, 1, 32'h22222222, 0,   0, 32'h1007C,    0, 32'h11111111, 32'h10074); // 9
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h1007C,    1, 32'h22222222, 32'h10078); // 10
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h1007C,    1, 32'h22222222, 32'h10078); // 11
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h1007C,    1, 32'h22222222, 32'h10078); // 12
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h1007C,    1, 32'h22222222, 32'h10078); // 13
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h1007C,    1, 32'h22222222, 32'h10078); // 14
    add(1, 1, 0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h1007C,    0, 32'h22222222, 32'h10078); // 15
    // redirect in WAIT, stale rvalid two cycles later
    add(1, 1, 1, 32'h10200,    0, 0, 32'h0,        1,   0, 32'h10080,    0, 32'h22222222, 32'h10078); // 16
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h10200,    0, 32'h22222222, 32'h10078); // 17
    add(1, 1, 0, 32'h0,        0, 1, 32'hDEADBEEF, 1,   0, 32'h10200,    0, 32'h22222222, 32'h10078); // 18
    add(1, 1, 0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h10200,    0, 32'h22222222, 32'h10078); // 19
    add(1, 1, 0, 32'h0,        0, 1, 32'h33333333, 1,   0, 32'h10204,    0, 32'h22222222, 32'h10078); // 20
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h10204,    1, 32'h33333333, 32'h10200); // 21
    // redirect and rvalid in the same cycle
    add(1, 1, 0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h10204,    0, 32'h33333333, 32'h10200); // 22
    add(1, 1, 1, 32'h10300,    0, 1, 32'hDEADBEEF, 1,   0, 32'h10208,    0, 32'h33333333, 32'h10200); // 23
    // redirect with grant in the same cycle, unaligned target
    add(1, 1, 1, 32'h10203,    1, 0, 32'h0,        1,   1, 32'h10300,    0, 32'h33333333, 32'h10200); // 24
    add(1, 1, 0, 32'h0,        0, 1, 32'hDEADBEEF, 1,   0, 32'h10200,    0, 32'h33333333, 32'h10200); // 25
    add(1, 1, 0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h10200,    0, 32'h33333333, 32'h10200); // 26
    add(1, 1, 0, 32'h0,        0, 1, 32'h44444444, 1,   0, 32'h10204,    0, 32'h33333333, 32'h10200); // 27
    // redirect in HOLD with ready in the same cycle
    add(1, 1, 1, 32'h10400,    0, 0, 32'h0,        1,   0, 32'h10204,    1, 32'h44444444, 32'h10200); // 28
    // fetch_en low does not withdraw a pending request
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h10400,    0, 32'h44444444, 32'h10200); // 29
    add(1, 0, 0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h10400,    0, 32'h44444444, 32'h10200); // 30
    add(1, 0, 0, 32'h0,        0, 1, 32'h55555555, 1,   0, 32'h10404,    0, 32'h44444444, 32'h10200); // 31
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h10404,    1, 32'h55555555, 32'h10400); // 32
    // redirect in IDLE to the top of the address space, then wrap
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h10404,    0, 32'h55555555, 32'h10400); // 33
    add(1, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        1,   0, 32'h10404,    0, 32'h55555555, 32'h10400); // 34
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'hFFFFFFFC, 0, 32'h55555555, 32'h10400); // 35
    add(1, 1, 0, 32'h0,        1, 0, 32'h0,        1,   1, 32'hFFFFFFFC, 0, 32'h55555555, 32'h10400); // 36
    add(1, 1, 0, 32'h0,        0, 1, 32'h66666666, 0,   0, 32'h00000000, 0, 32'h55555555, 32'h10400); // 37
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h00000000, 1, 32'h66666666, 32'hFFFFFFFC); // 38
    add(1, 1, 0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h00000000, 0, 32'h66666666, 32'hFFFFFFFC); // 39
    // reset in WAIT, stray rvalid afterwards
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h00000004, 0, 32'h66666666, 32'hFFFFFFFC); // 40
    add(1, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 1,   0, 32'h10074,    0, 32'h0,        32'h10074); // 41
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h10074,    0, 32'h0,        32'h10074); // 42
    add(1, 1, 0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h10074,    0, 32'h0,        32'h10074); // 43
    add(1, 1, 0, 32'h0,        0, 1, 32'h77777777, 1,   0, 32'h10078,    0, 32'h0,        32'h10074); // 44
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h10078,    1, 32'h77777777, 32'h10074); // 45
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h10078,    0, 32'h77777777, 32'h10074); // 46
  endtask

  // ---------------------------------------------------------------------------
  // Random-phase model state
  // ---------------------------------------------------------------------------
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];
  logic        outstanding;
  int          rv_cnt;
  logic [31:0] resp_addr;
  int          deliveries;

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_addr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;

    build_vectors();

    // Directed phase (first rising edge sees rst_n=0)
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_req", i),    {31'd0, imem_req},    {31'd0, vecs[i].ereq});
      chk($sformatf("v%0d_addr", i),   imem_addr,            vecs[i].eaddr);
      chk($sformatf("v%0d_valid", i),  {31'd0, instr_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d_instr", i),  instr,                vecs[i].einstr);
      chk($sformatf("v%0d_pc", i),     instr_pc,             vecs[i].eipc);
      chk($sformatf("v%0d_pc4", i),    instr_pc_plus4,       vecs[i].eipc + 32'd4);
      rst_n         = vecs[i].rst_n;
      fetch_en      = vecs[i].en;
      redirect      = vecs[i].redir;
      redirect_addr = vecs[i].raddr;
      imem_gnt      = vecs[i].gnt;
      imem_rvalid   = vecs[i].rv;
      imem_rdata    = vecs[i].rdata;
      instr_ready   = vecs[i].rdy;
      $display("vec %0d: req=%b addr=%h valid=%b instr=%h pc=%h", i, imem_req, imem_addr,
               instr_valid, instr, instr_pc);
    end

    // Randomized phase
    @(negedge clk);
    rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'h10074;
    exp_q.delete();
    outstanding = 1'b0;
    rv_cnt = 0;
    resp_addr = '0;
    deliveries = 0;

    for (int c = 0; c < 3000; c++) begin
      logic s_req, s_valid, rdy, redir, gnt, rv;
      logic [31:0] s_addr, s_instr, s_pc, s_pc4, raddr;
      @(negedge clk);
      s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
      s_instr = instr; s_pc = instr_pc; s_pc4 = instr_pc_plus4;

      if (s_req) begin
        chk("rnd_req_while_outstanding", {31'd0, s_req & outstanding}, 32'd0);
        chk("rnd_req_addr", s_addr, exp_pc);
      end
      if (s_valid) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_instr", {31'd0, s_valid}, 32'd0);
        end else begin
          chk("rnd_instr_pc", s_pc, exp_q[0]);
          chk("rnd_instr", s_instr, mem_word(exp_q[0]));
          chk("rnd_pc_plus4", s_pc4, exp_q[0] + 32'd4);
        end
      end

      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 19) == 0);
      raddr = $urandom;
      gnt   = s_req && ($urandom_range(0, 9) < 6);
      if (outstanding && rv_cnt == 0) begin
        rv = 1'b1; imem_rdata = mem_word(resp_addr);
      end else if (!outstanding && $urandom_range(0, 19) == 0) begin
        rv = 1'b1; imem_rdata = 32'hBAD0BAD0;
      end else begin
        rv = 1'b0; imem_rdata = $urandom;
      end
      fetch_en      = ($urandom_range(0, 9) != 0);
      instr_ready   = rdy;
      redirect      = redir;
      redirect_addr = raddr;
      imem_gnt      = gnt;
      imem_rvalid   = rv;

      // Model the coming rising edge
      if (s_valid && rdy && exp_q.size() > 0) begin
        $display("rnd deliver pc=%h instr=%h", s_pc, s_instr);
        void'(exp_q.pop_front());
        deliveries++;
      end
      if (outstanding) begin
        if (rv) outstanding = 1'b0;
        else rv_cnt--;
      end
      if (s_req && gnt) begin
        outstanding = 1'b1;
        rv_cnt      = $urandom_range(0, 2);
        resp_addr   = s_addr;
        if (!redir) begin
          exp_q.push_back(exp_pc);
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (redir) begin
        exp_pc = {raddr[31:2], 2'b00};
        exp_q.delete();
      end
    end

    chk("rnd_enough_deliveries", {31'd0, deliveries > 50}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
